irq_pending_arbiter: RTL and testbench
======================================

Name: irq_pending_arbiter

Overview:
- Captures up to N_REQ asynchronous-to-protocol request lines into a pending register.
- Selects the lowest-index unmasked pending line, using lowest-index-wins priority, the same rule as the team's 8:3 priority encoder.
- Presents the selected index to a downstream consumer over a valid/ready handshake and clears the served bit on acceptance.
- Sits directly upstream of the encoder consumer path and turns raw request pulses into a registered, held event stream.

Parameters:
- N_REQ, 8, number of request lines; power of two, 2..16.
- IDX_W, $clog2(N_REQ), derived index width; not overridden.
- EDGE_MODE, 1, 1 = rising-edge capture of req_i; 0 = level capture.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- req_i  in  N_REQ  request lines, already synchronous to clk.
- mask_i  in  N_REQ  1 = line ineligible for selection; the line still accumulates pending.
- evt_valid_o  out  1  event offered.
- evt_ready_i  in  1  consumer accepts the event when high with evt_valid_o.
- evt_idx_o  out  IDX_W  index of the offered line.
- pending_o  out  N_REQ  current pending register, registered.
- overflow_o  out  1  one-cycle pulse: new capture on a line that is already pending and not being cleared.

Behaviour:
- Reset (async, rst_n=0): pending=0, req_d=0, state=IDLE, evt_valid_o=0, evt_idx_o=0, overflow_o=0. Applies immediately, including mid-offer; an in-flight offer is dropped.
- Capture:
  - EDGE_MODE=1: rise = req_i & ~req_d, with req_d the registered req_i. A line already high at the first edge after reset counts as a rise.
  - EDGE_MODE=0: rise = req_i.
- Pending update each edge: pending <= (pending & ~clr) | rise, where clr = onehot(evt_idx_o) on handshake, else 0.
  - Set beats clear: a rise on the line being accepted leaves it pending, with no overflow.
- overflow_o registered: high for one cycle after any edge where (rise & pending & ~clr) != 0.
- eligible = pending & ~mask_i, evaluated combinationally from registered pending.
- FSM, two states:
  - IDLE: if eligible != 0, load evt_idx_o = lowest set index of eligible, set evt_valid_o=1, go OFFER. Otherwise stay, evt_valid_o=0.
  - OFFER: evt_valid_o and evt_idx_o held stable until evt_ready_i=1. On the handshake edge: clear the pending bit, evt_valid_o<=0, go IDLE.
  - An offer is never withdrawn or changed once made. Masking the line, or a higher-priority arrival during OFFER, has no effect until the next IDLE.
- Latency: req_i first sampled high at edge k → pending bit set after edge k → evt_valid_o high after edge k+1.
- Throughput: at most one event per 2 cycles, since IDLE is a mandatory bubble.
- evt_ready_i is ignored while evt_valid_o=0.
- All-masked case: pending is retained, no offer is made, and the offer resumes on the first IDLE cycle after unmasking.
- Width rules: evt_idx_o is the zero-extended binary index. No arithmetic beyond the priority scan.

Decomposition:
- Package irq_arb_pkg holds:
  - state enum {IDLE, OFFER}
  - localparam helper for IDX_W
  - function onehot(idx) returning N_REQ bits
- Sub-module prio_enc_lsb, parameterised N_REQ/IDX_W:
  - Purely combinational lowest-index-first encoder with an any_o flag.
  - Instantiated once on eligible.

Test Plan:
- Reset with req_i=8'h00, then req_i[5] 0→1 at edge 3 → pending_o=8'h20 after edge 3; evt_valid_o=1, evt_idx_o=5 after edge 4; hold evt_ready_i=0 for 4 cycles → outputs stable.
- req_i rises 8'h0C same cycle, evt_ready_i=1 continuous → events 2 then 3 on consecutive offers, a one-cycle valid-low gap between them, pending_o ends 8'h00.
- pending 8'h81, mask_i=8'h01 → idx 7 offered first; unmask bit 0 after accept → idx 0 offered.
- During OFFER of idx 4, pulse req_i[4] again → overflow_o one-cycle pulse. Pulse req_i[4] on the handshake edge → pending[4] stays 1, no overflow, re-offered as idx 4.
- Assert rst_n=0 mid-OFFER (idx 6) → evt_valid_o, pending_o, and evt_idx_o drop to 0 asynchronously. After release with req_i[6] held high in EDGE_MODE=1 → re-captured, offered idx 6.
- EDGE_MODE=0, req_i[1] held high → pending[1] re-sets every cycle; repeated idx 1 offers each accept, no overflow on accept edges.

Source files
------------

// File: rtl/irq_arb_pkg.sv
// Shared types and helpers for the pending-request arbiter: FSM states,
// index-width derivation and one-hot decode of a served index.
package irq_arb_pkg;

  localparam int unsigned MAX_REQ = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

  // Callers keep the low N_REQ bits of the result.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    logic [MAX_REQ-1:0] v;
    v = '0;
    v[idx[3:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-index-first priority encoder with an any-set flag.
module prio_enc_lsb #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scanning downward lets the lowest set index overwrite all others.
  always_comb begin
    idx_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/irq_pending_arbiter.sv
// Captures request pulses into a pending register and offers the lowest
// unmasked pending index downstream over a valid/ready handshake.
module irq_pending_arbiter
  import irq_arb_pkg::*;
#(
  parameter int N_REQ     = 8,
  parameter int IDX_W     = idx_width(N_REQ),
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDX_W-1:0] evt_idx_o,
  output logic [N_REQ-1:0] pending_o,
  output logic             overflow_o
);

  // Handshake: an event transfers on a rising edge where evt_valid_o and
  // evt_ready_i are both high; once raised, valid and index hold until then.

  arb_state_e         state_q, state_d;
  logic [N_REQ-1:0]   req_d_q;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               overflow_q, overflow_d;
  logic [N_REQ-1:0]   rise, clr, eligible;
  logic [MAX_REQ-1:0] clr_full;
  logic               unused_clr;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic               hs;

  always_comb begin
    if (EDGE_MODE != 0) rise = req_i & ~req_d_q;
    else                rise = req_i;
  end

  assign hs         = (state_q == OFFER) && evt_ready_i;
  assign clr_full   = onehot(32'(idx_q));
  assign unused_clr = ^clr_full;
  assign clr        = hs ? clr_full[N_REQ-1:0] : '0;
  assign eligible   = pending_q & ~mask_i;

  // A fresh rise wins over the clear of the line being served.
  assign pending_d  = (pending_q & ~clr) | rise;
  assign overflow_d = |(rise & pending_q & ~clr);

  prio_enc_lsb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_enc (
    .req_i (eligible),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          idx_d   = enc_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_d_q    <= '0;
      pending_q  <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_d_q    <= req_i;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_valid_o = (state_q == OFFER);
  assign evt_idx_o   = idx_q;
  assign pending_o   = pending_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Bench for irq_pending_arbiter: a level-mode and an edge-mode instance share
// stimulus and are compared every cycle against a behavioural model.
module tb_irq_pending_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ready;

  logic       valid_l, valid_e, ovf_l, ovf_e;
  logic [2:0] idx_l, idx_e;
  logic [7:0] pend_l, pend_e;

  int n_checks;
  int n_pass;

  // Model state, index 0 = level instance, 1 = edge instance.
  bit m_pend[2][8];
  bit m_valid[2];
  int m_idx[2];
  bit m_ovf[2];
  bit m_reqd[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  irq_pending_arbiter #(.N_REQ(8), .EDGE_MODE(0)) dut_l (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .mask_i      (mask),
    .evt_valid_o (valid_l),
    .evt_ready_i (ready),
    .evt_idx_o   (idx_l),
    .pending_o   (pend_l),
    .overflow_o  (ovf_l)
  );

  irq_pending_arbiter #(.N_REQ(8), .EDGE_MODE(1)) dut_e (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .mask_i      (mask),
    .evt_valid_o (valid_e),
    .evt_ready_i (ready),
    .evt_idx_o   (idx_e),
    .pending_o   (pend_e),
    .overflow_o  (ovf_e)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] pend_vec(input int k);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[k][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_pend[k][i] = 1'b0;
      m_valid[k] = 1'b0;
      m_idx[k]   = 0;
      m_ovf[k]   = 1'b0;
    end
    for (int i = 0; i < 8; i++) m_reqd[i] = 1'b0;
  endtask

  task automatic model_edge();
    bit np[8];
    bit r, cl, hs, ovf;
    int first;
    for (int k = 0; k < 2; k++) begin
      hs  = m_valid[k] && ready;
      ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin
        r  = (k == 0) ? req[i] : (req[i] && !m_reqd[i]);
        cl = hs && (m_idx[k] == i);
        if (r && m_pend[k][i] && !cl) ovf = 1'b1;
        np[i] = (m_pend[k][i] && !cl) || r;
      end
      if (!m_valid[k]) begin
        first = -1;
        for (int i = 0; i < 8; i++)
          if (first < 0 && m_pend[k][i] && !mask[i]) first = i;
        if (first >= 0) begin
          m_valid[k] = 1'b1;
          m_idx[k]   = first;
        end
      end else if (hs) begin
        m_valid[k] = 1'b0;
      end
      for (int i = 0; i < 8; i++) m_pend[k][i] = np[i];
      m_ovf[k] = ovf;
    end
    for (int i = 0; i < 8; i++) m_reqd[i] = req[i];
  endtask

  task automatic check_all();
    chk("l_valid", 32'(valid_l), 32'(m_valid[0]));
    chk("l_idx",   32'(idx_l),   32'(m_idx[0]));
    chk("l_pend",  32'(pend_l),  32'(pend_vec(0)));
    chk("l_ovf",   32'(ovf_l),   32'(m_ovf[0]));
    chk("e_valid", 32'(valid_e), 32'(m_valid[1]));
    chk("e_idx",   32'(idx_e),   32'(m_idx[1]));
    chk("e_pend",  32'(pend_e),  32'(pend_vec(1)));
    chk("e_ovf",   32'(ovf_e),   32'(m_ovf[1]));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 32'(valid_e), 32'd0);
    chk("rst_pend",  32'(pend_e),  32'd0);
    chk("rst_idx",   32'(idx_e),   32'd0);
    check_all();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    req   = 8'h00;
    mask  = 8'h00;
    ready = 1'b0;
    model_reset();
    #2;
    chk("reset_valid", 32'(valid_e), 32'd0);
    chk("reset_ovf",   32'(ovf_e),   32'd0);
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Edge-mode capture latency and offer stability under back-pressure.
    step();
    step();
    req = 8'h20;
    step();
    chk("cap_pend", 32'(pend_e), 32'h20);
    chk("cap_valid", 32'(valid_e), 32'd0);
    step();
    chk("offer_valid", 32'(valid_e), 32'd1);
    chk("offer_idx",   32'(idx_e),   32'd5);
    repeat (4) begin
      step();
      chk("hold_valid", 32'(valid_e), 32'd1);
      chk("hold_idx",   32'(idx_e),   32'd5);
    end
    ready = 1'b1;
    step();
    chk("accept_valid", 32'(valid_e), 32'd0);
    chk("accept_pend",  32'(pend_e),  32'h00);
    ready = 1'b0;
    req   = 8'h00;
    step();
    step();

    // Two simultaneous rises served in priority order with a bubble.
    req   = 8'h0C;
    ready = 1'b1;
    step();
    chk("pair_pend", 32'(pend_e), 32'h0C);
    req = 8'h00;
    step();
    chk("pair_idx2", 32'(idx_e), 32'd2);
    chk("pair_v2",   32'(valid_e), 32'd1);
    step();
    chk("pair_gap",  32'(valid_e), 32'd0);
    step();
    chk("pair_idx3", 32'(idx_e), 32'd3);
    step();
    chk("pair_end",  32'(pend_e), 32'h00);
    ready = 1'b0;
    step();

    // Masked lowest line is skipped, then served once unmasked.
    mask = 8'h01;
    req  = 8'h81;
    step();
    req = 8'h00;
    step();
    chk("mask_idx7", 32'(idx_e), 32'd7);
    ready = 1'b1;
    step();
    mask = 8'h00;
    step();
    chk("unmask_idx0", 32'(idx_e), 32'd0);
    chk("unmask_v",    32'(valid_e), 32'd1);
    step();
    ready = 1'b0;
    step();

    // Overflow on re-capture while pending; set beats clear on accept.
    req = 8'h10;
    step();
    req = 8'h00;
    step();
    chk("ovf_offer", 32'(idx_e), 32'd4);
    req = 8'h10;
    step();
    chk("ovf_pulse", 32'(ovf_e), 32'd1);
    req = 8'h00;
    step();
    chk("ovf_clear", 32'(ovf_e), 32'd0);
    req   = 8'h10;
    ready = 1'b1;
    step();
    chk("setclr_pend", 32'(pend_e), 32'h10);
    chk("setclr_ovf",  32'(ovf_e),  32'd0);
    req   = 8'h00;
    ready = 1'b0;
    step();
    chk("reoffer_idx", 32'(idx_e), 32'd4);
    ready = 1'b1;
    step();
    ready = 1'b0;

    // Async reset mid-offer, then a held line is captured again.
    req = 8'h40;
    step();
    step();
    chk("pre_rst_idx", 32'(idx_e), 32'd6);
    async_reset();
    step();
    chk("recap_pend", 32'(pend_e), 32'h40);
    step();
    chk("recap_idx",  32'(idx_e), 32'd6);
    chk("recap_v",    32'(valid_e), 32'd1);
    req = 8'h00;

    // Level mode with a held line: re-offered after each accept.
    async_reset();
    req   = 8'h02;
    ready = 1'b1;
    step();
    repeat (3) begin
      step();
      chk("lvl_valid", 32'(valid_l), 32'd1);
      chk("lvl_idx",   32'(idx_l),   32'd1);
      step();
      chk("lvl_acc_ovf", 32'(ovf_l), 32'd0);
      chk("lvl_pend",    32'(pend_l), 32'h02);
    end
    req   = 8'h00;
    ready = 1'b0;

    // Randomised traffic against the model.
    repeat (400) begin
      req   = 8'($urandom) & 8'($urandom);
      mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ready = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
